// File: rtl/rs_pkg.sv
// rs_pkg: shared RS(255,239) field constants and GF(2^8) arithmetic
package rs_pkg;
    localparam int RS_N = 255;
    localparam int RS_K = 239;
    localparam int RS_NSYM = RS_N - RS_K;
    localparam logic [8:0] GF_PRIM_POLY = 9'h11D;
    localparam logic [7:0] ALPHA_POW [0:RS_NSYM-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26
    };
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = x[7] ? {x[6:0], 1'b0} ^ GF_PRIM_POLY[7:0] : {x[6:0], 1'b0};
        end
        return p;
    endfunction
endpackage

// File: rtl/rs_syndrome_cell.sv
// rs_syndrome_cell: one Horner accumulator evaluating r(alpha^J)
module rs_syndrome_cell
    import rs_pkg::*;
#(
    parameter int J = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       first_i,
    input  logic [7:0] sym_i,
    output logic [7:0] acc_d_o
);
    logic [7:0] acc_q;
    logic [7:0] acc_d;
    // first symbol of a codeword loads directly; later ones do acc*alpha^J + r
    always_comb acc_d = first_i ? sym_i : gf_mul(acc_q, ALPHA_POW[J]) ^ sym_i;
    // accumulator advances only on accepted symbols
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else if (en_i) acc_q <= acc_d;
    end
    assign acc_d_o = acc_d;
endmodule

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: streaming RS(255,239) syndrome calculator
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int N    = RS_N,
    parameter int K    = RS_K,
    parameter int NSYM = N - K
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic [8*NSYM-1:0] syndrome,
    output logic              syn_valid,
    output logic              err_flag,
    output logic [7:0]        sym_cnt
);
    logic [7:0]        sym_cnt_q;
    logic [7:0]        sym_cnt_d;
    logic              first;
    logic              last;
    logic [8*NSYM-1:0] acc_d_all;
    logic [8*NSYM-1:0] syndrome_q;
    logic              syn_valid_q;
    logic              err_flag_q;
    // framing is purely count based: index 0 loads, index N-1 completes
    always_comb begin
        first     = sym_cnt_q == '0;
        last      = data_valid && sym_cnt_q == 8'(N - 1);
        sym_cnt_d = !data_valid ? sym_cnt_q : (sym_cnt_q == 8'(N - 1) ? '0 : sym_cnt_q + 8'd1);
    end
    for (genvar j = 0; j < NSYM; j++) begin : g_cell
        rs_syndrome_cell #(.J(j)) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (data_valid),
            .first_i(first),
            .sym_i  (data_in),
            .acc_d_o(acc_d_all[8*j +: 8])
        );
    end
    // symbol counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sym_cnt_q <= '0;
        else sym_cnt_q <= sym_cnt_d;
    end
    // capture final accumulator values when the last symbol is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syndrome_q  <= '0;
            syn_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            syn_valid_q <= last;
            if (last) begin
                syndrome_q <= acc_d_all;
                err_flag_q <= |acc_d_all;
            end
        end
    end
    assign syndrome  = syndrome_q;
    assign syn_valid = syn_valid_q;
    assign err_flag  = err_flag_q;
    assign sym_cnt   = sym_cnt_q;
endmodule
